// File: rtl/logic_gate_checker_if.sv
// logic_gate_checker_if: stimulus, gate responses and verdict between the checker and the gate block
interface logic_gate_checker_if;
    logic start;
    logic a, b;
    logic and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g;
    logic busy, done, pass;
    logic [3:0] fail_vec;
    logic [6:0] fail_mask;
    modport master (
        input start, and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g,
        output a, b, busy, done, pass, fail_vec, fail_mask
    );
    modport slave (
        output start, and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g,
        input a, b, busy, done, pass, fail_vec, fail_mask
    );
endinterface

// File: rtl/logic_gate_checker.sv
// logic_gate_checker: walks a/b through all four vectors and checks the seven gate responses
module logic_gate_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic clk,
    input logic rst_n,
    logic_gate_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, state_n;
    logic [7:0] cnt;
    logic [1:0] vec;
    logic [6:0] mism;
    logic launch, settled;
    always_comb begin
        mism = {~(vec[1] ^ vec[0]), vec[1] ^ vec[0], ~(vec[1] | vec[0]), ~(vec[1] & vec[0]),
                ~vec[1], vec[1] | vec[0], vec[1] & vec[0]}
             ^ {bus.xnor_g, bus.xor_g, bus.nor_g, bus.nand_g, bus.not_g, bus.or_g, bus.and_g};
        // the edge closing DONE already behaves as IDLE, so back-to-back runs are 4*(S+1)+1 apart
        launch = bus.start && (state == IDLE || state == DONE);
        settled = cnt == 8'(SETTLE_CYCLES - 1);
        state_n = launch ? SETTLE :
                  state == SETTLE ? (settled ? SAMPLE : SETTLE) :
                  state == SAMPLE ? (vec == 2'd3 ? DONE : SETTLE) :
                  state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            vec <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail_vec <= '0;
            bus.fail_mask <= '0;
        end else begin
            state <= state_n;
            bus.done <= state_n == DONE;
            if (launch) begin
                cnt <= '0;
                vec <= '0;
                bus.busy <= 1'b1;
                bus.pass <= 1'b0;
                bus.fail_vec <= '0;
                bus.fail_mask <= '0;
            end else if (state == SETTLE) begin
                cnt <= cnt + 8'd1;
            end else if (state == SAMPLE) begin
                bus.fail_mask <= bus.fail_mask | mism;
                bus.fail_vec[vec] <= |mism;
                bus.pass <= vec == 2'd3 && bus.fail_vec == 4'd0 && mism == 7'd0;
                if (vec != 2'd3) begin
                    vec <= vec + 2'd1;
                    cnt <= '0;
                end
            end else if (state == DONE) begin
                bus.busy <= 1'b0;
            end
        end
    end
    assign bus.a = vec[1];
    assign bus.b = vec[0];
endmodule

// File: tb/tb_logic_gate_checker.sv
// tb_logic_gate_checker: scoreboard bench driving two checkers (S=2, S=1) from a faulty/delayed gate-block model
module tb_logic_gate_checker;
    typedef struct {
        int dut;
        int cyc;
        logic pass;
        logic [3:0] fv;
        logic [6:0] fm;
    } rec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] start = '0;
    int fault = 0;
    int gidx = 0;
    logic sval = 1'b0;
    logic [1:0] dly = '0;
    int cyc = 0;
    int e0 = 0;
    int sel = 0;
    bit active = 1'b0;
    int compared = 0;
    int mismatched = 0;
    logic [1:0] last_ab [2] = '{2'd0, 2'd0};
    rec_t q [$];
    logic [1:0] ab [2];
    logic [3:0] fv [2];
    logic [6:0] fm [2];
    logic [1:0] busy, done, pass;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // truth tables indexed by {a,b}, in and/or/not/nand/nor/xor/xnor order
    function automatic logic [6:0] ideal(logic [1:0] v);
        logic [3:0] tt [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        logic [6:0] g;
        for (int i = 0; i < 7; i++) g[i] = tt[i][v];
        return g;
    endfunction

    function automatic logic [6:0] gate_fn(logic [1:0] v, int f, int gi, logic sv);
        logic [6:0] g;
        g = ideal(v);
        if (f == 1) g[5] = 1'b0;
        else if (f == 2) g[2] = v[0];
        else if (f == 3) g[gi] = sv;
        return g;
    endfunction

    function automatic rec_t model(int g);
        rec_t r;
        int s;
        logic [1:0] seen;
        logic [6:0] diff;
        s = g == 0 ? 2 : 1;
        r.dut = g;
        r.cyc = 0;
        r.fv = '0;
        r.fm = '0;
        for (int v = 0; v < 4; v++) begin
            // a response delayed past the settle window shows the previous vector
            seen = s >= int'(dly) ? 2'(v) : (v == 0 ? last_ab[g] : 2'(v - 1));
            diff = gate_fn(seen, fault, gidx, sval) ^ ideal(2'(v));
            r.fm = r.fm | diff;
            r.fv[v] = |diff;
        end
        r.pass = r.fv == 4'd0;
        return r;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        logic_gate_checker_if bus ();
        logic [6:0] pipe [3];
        logic [6:0] comb_out, gout;
        assign comb_out = gate_fn({bus.a, bus.b}, fault, gidx, sval);
        assign gout = dly == 2'd0 ? comb_out : dly == 2'd1 ? pipe[0] : dly == 2'd2 ? pipe[1] : pipe[2];
        always @(posedge clk) begin
            pipe[0] <= comb_out;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign bus.start = start[g];
        assign {bus.xnor_g, bus.xor_g, bus.nor_g, bus.nand_g, bus.not_g, bus.or_g, bus.and_g} = gout;
        assign ab[g] = {bus.a, bus.b};
        assign busy[g] = bus.busy;
        assign done[g] = bus.done;
        assign pass[g] = bus.pass;
        assign fv[g] = bus.fail_vec;
        assign fm[g] = bus.fail_mask;
        logic_gate_checker #(.SETTLE_CYCLES(g == 0 ? 2 : 1)) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus.master)
        );
    end

    always @(negedge clk) begin
        int s;
        int step;
        rec_t r;
        s = sel == 0 ? 2 : 1;
        if (active && cyc >= e0 && cyc <= e0 + 4 * (s + 1)) begin
            step = (cyc - e0) / (s + 1);
            chk("ab_step", 32'(ab[sel]), step > 3 ? 3 : step);
            chk("busy_run", 32'(busy[sel]), 1);
        end
        for (int g = 0; g < 2; g++) begin
            if (done[g] === 1'b1) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_done: dut%0d pulsed done at cycle %0d, none expected", g, cyc);
                end else begin
                    r = q.pop_front();
                    chk("done_dut", g, r.dut);
                    chk("done_cycle", cyc, r.cyc);
                    chk("pass", 32'(pass[g]), 32'(r.pass));
                    chk("fail_vec", 32'(fv[g]), 32'(r.fv));
                    chk("fail_mask", 32'(fm[g]), 32'(r.fm));
                    chk("busy_done", 32'(busy[g]), 1);
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: %0d run(s) never reported done", q.size());
            q.delete();
        end
    endtask

    task automatic run(int g);
        rec_t r;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy[g]), 0);
        r = model(g);
        r.cyc = cyc + 1 + 4 * ((g == 0 ? 2 : 1) + 1);
        q.push_back(r);
        sel = g;
        e0 = cyc + 1;
        active = 1'b1;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        wait_drain();
        active = 1'b0;
        last_ab[g] = 2'd3;
    endtask

    initial begin
        rec_t r;
        repeat (4) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ab", 32'(ab[g]), 0);
            chk("rst_busy", 32'(busy[g]), 0);
            chk("rst_done", 32'(done[g]), 0);
            chk("rst_pass", 32'(pass[g]), 0);
            chk("rst_fail_vec", 32'(fv[g]), 0);
            chk("rst_fail_mask", 32'(fm[g]), 0);
        end
        rst_n = 1'b1;
        run(0);
        chk("good_pass", 32'(pass[0]), 1);
        fault = 1;
        run(0);
        chk("xor0_fail_vec", 32'(fv[0]), 32'h6);
        chk("xor0_fail_mask", 32'(fm[0]), 32'h20);
        chk("xor0_pass", 32'(pass[0]), 0);
        fault = 2;
        run(0);
        chk("notb_fail_vec", 32'(fv[0]), 32'h9);
        chk("notb_fail_mask", 32'(fm[0]), 32'h04);
        fault = 0;
        repeat (5) @(negedge clk);
        sel = 0;
        r = model(0);
        r.cyc = cyc + 13;
        q.push_back(r);
        r.cyc = cyc + 26;
        q.push_back(r);
        e0 = cyc + 1;
        active = 1'b1;
        start[0] = 1'b1;
        while (cyc < e0 + 13) @(negedge clk);
        e0 = cyc;
        start[0] = 1'b0;
        wait_drain();
        active = 1'b0;
        last_ab[0] = 2'd3;
        chk("held_pass", 32'(pass[0]), 1);
        fault = 1;
        repeat (5) @(negedge clk);
        sel = 0;
        e0 = cyc + 1;
        active = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (cyc < e0 + 6) @(negedge clk);
        active = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ab", 32'(ab[0]), 0);
        chk("midrst_busy", 32'(busy[0]), 0);
        chk("midrst_done", 32'(done[0]), 0);
        chk("midrst_pass", 32'(pass[0]), 0);
        chk("midrst_fail_vec", 32'(fv[0]), 0);
        chk("midrst_fail_mask", 32'(fm[0]), 0);
        last_ab[0] = 2'd0;
        last_ab[1] = 2'd0;
        repeat (20) @(negedge clk);
        fault = 0;
        run(0);
        chk("after_rst_pass", 32'(pass[0]), 1);
        dly = 2'd1;
        run(1);
        chk("s1_dly1_pass", 32'(pass[1]), 1);
        dly = 2'd2;
        run(1);
        chk("s1_dly2_pass", 32'(pass[1]), 0);
        for (int n = 0; n < 40; n++) begin
            fault = $urandom_range(0, 3);
            gidx = $urandom_range(0, 6);
            sval = 1'($urandom_range(0, 1));
            dly = 2'($urandom_range(0, 3));
            run($urandom_range(0, 1));
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
